frame_ram_arbiter: RTL and testbench

//  Owns the single-port processed-picture RAM shared by the defog writer and the display reader.
//  The writer streams one 480x270 picture through a small FIFO into the RAM; display reads get priority.
//  pic_done is raised frame-aligned at a vsync rising edge, so the display never shows a partial picture.

---
 rtl/frame_ram_pkg.sv | 24 ++
 rtl/frame_ram_arbiter_fifo.sv | 66 ++++++
 rtl/frame_ram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_ram_pkg.sv
// Shared types and default sizing for the processed-picture RAM arbiter.
// Holds the arbiter state encoding and the default geometry of one 480x270 RGB888 picture.
package frame_ram_pkg;

    localparam int unsigned ADDR_W     = 17;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned PIC_PIXELS = 480 * 270;
    localparam int unsigned FIFO_AW    = 4;
    localparam int unsigned STARVE_LIM = 64;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        WAIT_VS,
        DONE
    } state_e;

    // A picture is in flight anywhere between accepting wr_start and publishing it.
    function automatic logic is_busy(input state_e s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/frame_ram_arbiter_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
// Decouples the writer stream from RAM slots stolen by display reads.
module sync_fifo #(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned DATA_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);
    import frame_ram_pkg::*;

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_full;
    logic               r_empty;
    logic               w_push;
    logic               w_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push       = i_push && (!r_full || i_pop);
    assign w_pop        = i_pop && !r_empty;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port picture RAM arbiter: display reads win, writer pixels drain through a FIFO,
// and pic_done is published only on a vsync edge. ARB_STARVE_EN adds a forced-write escape.
module frame_ram_arbiter #(
    parameter int unsigned ADDR_W     = frame_ram_pkg::ADDR_W,
    parameter int unsigned DATA_W     = frame_ram_pkg::DATA_W,
    parameter int unsigned PIC_PIXELS = frame_ram_pkg::PIC_PIXELS,
    parameter int unsigned FIFO_AW    = frame_ram_pkg::FIFO_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              pic_done,
    output logic              busy,
    output logic              starve_hit
);
    import frame_ram_pkg::*;

    state_e             r_state;
    state_e             w_state_next;
    logic               w_start_ok;
    logic               r_vsync_d;
    logic               w_vsync_rise;
    logic [ADDR_W-1:0]  r_acnt;
    logic [ADDR_W-1:0]  r_wcnt;
    logic               w_wr_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_can_pop;
    logic               w_force;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [DATA_W-1:0]  w_fifo_head;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_wdata;
    logic               r_pic_done;
    logic               r_busy;

    assign w_vsync_rise = vsync && !r_vsync_d;
    assign w_wr_ready   = (r_state == FILL) && !w_fifo_full && (r_acnt < ADDR_W'(PIC_PIXELS));
    assign w_push       = wr_valid && w_wr_ready;
    assign w_can_pop    = !w_fifo_empty && ((r_state == FILL) || (r_state == DRAIN));
    assign w_pop        = w_force || (!rd_req && w_can_pop);

    sync_fifo #(
        .FIFO_AW (FIFO_AW),
        .DATA_W  (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // wr_start is honoured only between pictures; in WAIT_VS the vsync edge alone decides.
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (wr_start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (r_acnt == ADDR_W'(PIC_PIXELS)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_empty && (r_wcnt == ADDR_W'(PIC_PIXELS))) begin
                    w_state_next = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (w_vsync_rise) begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_acnt    <= '0;
            r_wcnt    <= '0;
        end else begin
            r_vsync_d <= vsync;
            if (w_start_ok) begin
                r_acnt <= '0;
                r_wcnt <= '0;
            end else begin
                if (w_push) begin
                    r_acnt <= r_acnt + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_wcnt <= r_wcnt + ADDR_W'(1);
                end
            end
        end
    end

    // RAM port slot: a forced write beats a read, a read beats a normal write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_pic_done  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pic_done <= (w_state_next == DONE);
            r_busy     <= is_busy(w_state_next);
            if (w_pop) begin
                r_ram_we    <= 1'b1;
                r_ram_addr  <= r_wcnt;
                r_ram_wdata <= w_fifo_head;
            end else if (rd_req) begin
                r_ram_we   <= 1'b0;
                r_ram_addr <= rd_addr;
            end else begin
                r_ram_we <= 1'b0;
            end
        end
    end

`ifdef ARB_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_starve_hit;
    logic                w_starving;

    assign w_starving = w_fifo_full && rd_req;
    assign w_force    = w_starving && (r_starve_cnt == STARVE_W'(STARVE_LIM - 1));

    // Counts consecutive cycles where a full FIFO is blocked by reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_starve_hit <= 1'b0;
        end else begin
            r_starve_hit <= w_force;
            if (w_force || !w_starving) begin
                r_starve_cnt <= '0;
            end else begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign starve_hit = r_starve_hit;
`else
    assign w_force    = 1'b0;
    assign starve_hit = 1'b0;
`endif

    assign wr_ready  = w_wr_ready;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign pic_done  = r_pic_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter with a 16-pixel picture.
// RAM writes are checked against a scoreboard queue filled as pixels are handed over.
module tb_frame_ram_arbiter;

    localparam int unsigned TB_PIC = 16;

    logic        clk;
    logic        rst_n;
    logic        vsync;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        wr_start;
    logic        wr_valid;
    logic [23:0] wr_data;
    logic        wr_ready;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [23:0] ram_wdata;
    logic        pic_done;
    logic        busy;
    logic        starve_hit;

    typedef struct {
        logic [16:0] addr;
        logic [23:0] data;
    } wr_t;

    typedef struct {
        logic        rd_req;
        logic [16:0] rd_addr;
        logic        wr_valid;
        logic        wr_start;
        logic        exp_we;
        logic [16:0] exp_addr;
        logic        exp_ready;
        logic        exp_busy;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   checks;
    int   errors;
    int   n_writes;
    int   exp_addr;
    int   cyc_n;
    int   first_acc_cyc;
    int   first_wr_cyc;

    frame_ram_arbiter #(.PIC_PIXELS(TB_PIC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .wr_start   (wr_start),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .pic_done   (pic_done),
        .busy       (busy),
        .starve_hit (starve_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RAM write monitor, sampled 2ns after the rising edge.
    always @(posedge clk) begin
        wr_t e;
        #2;
        if (rst_n && ram_we) begin
            if (n_writes == 0) first_wr_cyc = cyc_n;
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write", ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.addr));
                chk("wr_data", 32'(ram_wdata), 32'(e.data));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // One pixel per cycle; pixels past the picture size must be refused.
    task automatic drive_pic(input logic [23:0] base, input int n_total);
        for (int i = 0; i < n_total; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 24'(i + 1);
            if (i == 0) first_acc_cyc = cyc_n;
            if (i < int'(TB_PIC)) begin
                chk("px_ready", 32'(wr_ready), 32'd1);
                if (wr_ready) begin
                    exp_q.push_back('{17'(exp_addr), wr_data});
                    exp_addr++;
                end
            end else begin
                chk("px_refused", 32'(wr_ready), 32'd0);
            end
            cyc();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int k = 0;
        while (n_writes < target && k < 100) begin
            cyc();
            k++;
        end
        cyc();
        cyc();
        chk("write_count", 32'(n_writes), 32'(target));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic finish_pic();
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_done", 32'(pic_done), 32'd0);
        chk("wait_no_ready", 32'(wr_ready), 32'd0);
        vsync = 1'b1;
        cyc();
        chk("vs_pic_done", 32'(pic_done), 32'd1);
        chk("vs_not_busy", 32'(busy), 32'd0);
        vsync = 1'b0;
        cyc();
    endtask

    task automatic start_pic();
        n_writes = 0;
        exp_addr = 0;
        wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
        chk("start_no_done", 32'(pic_done), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        int acc;
        checks = 0; errors = 0; n_writes = 0; exp_addr = 0; cyc_n = 0;
        rst_n = 1'b0; vsync = 1'b0; rd_req = 1'b0; rd_addr = '0;
        wr_start = 1'b0; wr_valid = 1'b0; wr_data = '0;

        vecs[0] = '{1'b1, 17'h00005, 1'b0, 1'b0, 1'b0, 17'h00005, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 17'h1FFFF, 1'b1, 1'b0, 1'b0, 17'h00005, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b0, 17'h1FFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 17'h0ABCD, 1'b1, 1'b0, 1'b0, 17'h0ABCD, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 17'h00000, 1'b1, 1'b0, 1'b0, 17'h0ABCD, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 17'h00000, 1'b0, 1'b1, 1'b0, 17'h0ABCD, 1'b1, 1'b1};

        // Reset state
        repeat (3) cyc();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_pic_done", 32'(pic_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_starve", 32'(starve_hit), 32'd0);
        rst_n = 1'b1;
        cyc();

        // IDLE read-through, refused writer pixels, then the picture start
        for (int v = 0; v < 6; v++) begin
            rd_req   = vecs[v].rd_req;
            rd_addr  = vecs[v].rd_addr;
            wr_valid = vecs[v].wr_valid;
            wr_start = vecs[v].wr_start;
            wr_data  = 24'hDEAD00 + 24'(v);
            cyc();
            chk("vec_we", 32'(ram_we), 32'(vecs[v].exp_we));
            chk("vec_addr", 32'(ram_addr), 32'(vecs[v].exp_addr));
            chk("vec_ready", 32'(wr_ready), 32'(vecs[v].exp_ready));
            chk("vec_busy", 32'(busy), 32'(vecs[v].exp_busy));
        end
        rd_req = 1'b0; wr_valid = 1'b0; wr_start = 1'b0; rd_addr = '0;

        // Picture 1: back-to-back pixels 1..16, writes to 0..15, done on vsync
        drive_pic(24'h000000, 16);
        wait_writes(16);
        chk("latency", 32'(first_wr_cyc - first_acc_cyc), 32'd2);
        cyc();
        finish_pic();

        // Picture 2: start from DONE, reads block writes for 40 cycles, wr_start in DRAIN ignored
        chk("done_held", 32'(pic_done), 32'd1);
        start_pic();
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            rd_req   = 1'b1;
            rd_addr  = 17'h01000 + 17'(k);
            wr_start = (k == 30);
            wr_valid = 1'b1;
            wr_data  = 24'h200001 + 24'(acc);
            if (wr_ready) begin
                exp_q.push_back('{17'(exp_addr), wr_data});
                exp_addr++;
                acc++;
            end
            cyc();
            chk("rd_we_low", 32'(ram_we), 32'd0);
            chk("rd_addr_follow", 32'(ram_addr), 32'(17'h01000 + 17'(k)));
        end
        chk("rd_accepts", 32'(acc), 32'd16);
        chk("rd_ready_low", 32'(wr_ready), 32'd0);
`ifndef ARB_STARVE_EN
        chk("starve_tied", 32'(starve_hit), 32'd0);
`endif
        rd_req = 1'b0; wr_valid = 1'b0; wr_start = 1'b0;
        wait_writes(16);
        // vsync edge and wr_start together in WAIT_VS: the edge wins
        chk("wait2_no_done", 32'(pic_done), 32'd0);
        chk("wait2_busy", 32'(busy), 32'd1);
        vsync = 1'b1; wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
        chk("vs_wins_done", 32'(pic_done), 32'd1);
        chk("vs_wins_idle", 32'(busy), 32'd0);
        cyc();
        chk("start_not_latched", 32'(pic_done), 32'd1);
        vsync = 1'b0;
        cyc();

        // Picture 3: 20 pixels offered, exactly 16 accepted
        start_pic();
        drive_pic(24'h300000, 20);
        wait_writes(16);
        chk("latency3", 32'(first_wr_cyc - first_acc_cyc), 32'd2);
        finish_pic();

        // Abort: reset after 7 writes with pixels still queued behind reads
        start_pic();
        drive_pic(24'h500000, 7);
        wait_writes(7);
        rd_req = 1'b1;
        drive_pic(24'h500100, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pic_done", 32'(pic_done), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd0);
        chk("arst_ram_we", 32'(ram_we), 32'd0);
        chk("arst_ram_addr", 32'(ram_addr), 32'd0);
        exp_q.delete();
        rd_req = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        start_pic();
        drive_pic(24'h400000, 16);
        wait_writes(16);
        finish_pic();

`ifdef ARB_STARVE_EN
        // Full FIFO blocked by reads: one forced write on the 64th full cycle
        begin
            int pulses;
            int pulse_k;
            pulses = 0;
            pulse_k = 0;
            start_pic();
            rd_req = 1'b1;
            drive_pic(24'h600000, 16);
            for (int k = 1; k <= 150; k++) begin
                if (starve_hit) begin
                    pulses++;
                    pulse_k = k;
                end
                cyc();
            end
            chk("starve_pulses", 32'(pulses), 32'd1);
            chk("starve_cycle", 32'(pulse_k), 32'd64);
            chk("starve_writes", 32'(n_writes), 32'd1);
            rd_req = 1'b0;
            wait_writes(16);
            finish_pic();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
